// File: rtl/vga_sync_gen.sv
// VGA timing source: x/y counters, registered syncs, video_on and strobes.
// Ports: clk, rst_n (sync, active-low) in; x, y, video_on, hsync, vsync,
// p_tick, line_start, frame_start, sec_tick out.
module vga_sync_gen #(
  parameter int H_VIS          = 800,
  parameter int H_FP           = 56,
  parameter int H_SYNC         = 120,
  parameter int H_BP           = 64,
  parameter int V_VIS          = 600,
  parameter int V_FP           = 37,
  parameter int V_SYNC         = 6,
  parameter int V_BP           = 23,
  parameter int SYNC_POL       = 1,
  parameter int CLK_DIV        = 1,
  parameter int FRAMES_PER_SEC = 72
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        p_tick,
  output logic        line_start,
  output logic        frame_start,
  output logic        sec_tick
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // 12-bit bounds so an end-of-range equal to 2048 still compares right
  localparam logic [11:0] H_VEND = 12'(H_VIS);
  localparam logic [11:0] HS_BEG = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_END = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [11:0] V_VEND = 12'(V_VIS);
  localparam logic [11:0] VS_BEG = 12'(V_VIS + V_FP);
  localparam logic [11:0] VS_END = 12'(V_VIS + V_FP + V_SYNC);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [6:0]    FPS_LAST = 7'(FRAMES_PER_SEC - 1);
  localparam logic          POL      = 1'(SYNC_POL);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [6:0]    frame_cnt;
  logic          en;
  logic          h_wrap;
  logic          v_wrap;
  logic [10:0]   x_nxt;
  logic [10:0]   y_nxt;
  logic [11:0]   xw;
  logic [11:0]   yw;
  logic          von_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          ls_nxt;
  logic          fs_nxt;
  logic          st_nxt;

  always_comb begin
    en      = (div_cnt == DIV_LAST);
    div_nxt = en ? '0 : div_cnt + 1'b1;
    h_wrap  = (x == H_LAST);
    v_wrap  = (y == V_LAST);
    x_nxt   = h_wrap ? '0 : x + 11'd1;
    y_nxt   = y;
    if (h_wrap) begin
      y_nxt = v_wrap ? '0 : y + 11'd1;
    end
    xw      = {1'b0, x_nxt};
    yw      = {1'b0, y_nxt};
    // decode the values x/y are about to take, so the flops line up
    von_nxt = (xw < H_VEND) && (yw < V_VEND);
    hs_nxt  = ((xw >= HS_BEG) && (xw < HS_END)) ? POL : ~POL;
    vs_nxt  = ((yw >= VS_BEG) && (yw < VS_END)) ? POL : ~POL;
    ls_nxt  = en && h_wrap;
    fs_nxt  = ls_nxt && v_wrap;
    st_nxt  = fs_nxt && (frame_cnt == FPS_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      frame_cnt   <= '0;
      x           <= H_LAST;
      y           <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      p_tick      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sec_tick    <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      p_tick      <= en;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      sec_tick    <= st_nxt;
      if (fs_nxt) begin
        frame_cnt <= st_nxt ? '0 : frame_cnt + 7'd1;
      end
      if (en) begin
        x        <= x_nxt;
        y        <= y_nxt;
        video_on <= von_nxt;
        hsync    <= hs_nxt;
        vsync    <= vs_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default, CLK_DIV=2/neg-sync and a tiny
// frame configuration for vertical timing, sec_tick and mid-frame reset.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic rst_d = 1'b0;
  logic [10:0] d_x, d_y;
  logic d_von, d_hs, d_vs, d_pt, d_ls, d_fs, d_st;
  vga_sync_gen u_def (
    .clk(clk), .rst_n(rst_d), .x(d_x), .y(d_y), .video_on(d_von),
    .hsync(d_hs), .vsync(d_vs), .p_tick(d_pt), .line_start(d_ls),
    .frame_start(d_fs), .sec_tick(d_st)
  );

  // CLK_DIV=2, negative syncs
  logic rst_c = 1'b0;
  logic [10:0] c_x, c_y;
  logic c_von, c_hs, c_vs, c_pt, c_ls, c_fs, c_st;
  vga_sync_gen #(.CLK_DIV(2), .SYNC_POL(0)) u_div (
    .clk(clk), .rst_n(rst_c), .x(c_x), .y(c_y), .video_on(c_von),
    .hsync(c_hs), .vsync(c_vs), .p_tick(c_pt), .line_start(c_ls),
    .frame_start(c_fs), .sec_tick(c_st)
  );

  // tiny frame: 14 x 7 = 98 clks, sec_tick every 3 frames
  logic rst_s = 1'b0;
  logic [10:0] s_x, s_y;
  logic s_von, s_hs, s_vs, s_pt, s_ls, s_fs, s_st;
  vga_sync_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FRAMES_PER_SEC(3)
  ) u_small (
    .clk(clk), .rst_n(rst_s), .x(s_x), .y(s_y), .video_on(s_von),
    .hsync(s_hs), .vsync(s_vs), .p_tick(s_pt), .line_start(s_ls),
    .frame_start(s_fs), .sec_tick(s_st)
  );

  typedef struct {
    logic        rst;
    int          adv;
    logic [10:0] x;
    logic [10:0] y;
    logic        von, hs, vs, pt, ls, fs;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [28:0] act,
                     input logic [28:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d f=%b want x=%0d y=%0d f=%b",
               nm, $time, act[28:18], act[17:7], act[6:0],
               exp[28:18], exp[17:7], exp[6:0]);
    end
  endtask

  // expected {x,y,von,hs,vs,pt,ls,fs,st} after idx counter updates
  // (idx<0 = reset values); tick marks a p_tick cycle
  function automatic logic [28:0] model(
    input int idx, input bit tick,
    input int hv, input int hf, input int hs, input int hb,
    input int vv, input int vf, input int vs, input int vb,
    input bit pol, input int fps);
    int ht, vt, xe, ye, fr;
    bit von, hsa, vsa, ls, fs, st;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    if (idx < 0)
      return {11'(ht - 1), 11'(vt - 1), 1'b0, ~pol, ~pol, 4'b0000};
    xe  = idx % ht;
    ye  = (idx / ht) % vt;
    fr  = idx / (ht * vt);
    von = (xe < hv) && (ye < vv);
    hsa = (xe >= hv + hf) && (xe < hv + hf + hs);
    vsa = (ye >= vv + vf) && (ye < vv + vf + vs);
    ls  = tick && (xe == 0);
    fs  = ls && (ye == 0);
    st  = fs && ((fr % fps) == fps - 1);
    return {11'(xe), 11'(ye), von, hsa ? pol : ~pol, vsa ? pol : ~pol,
            tick, ls, fs, st};
  endfunction

  function automatic logic [28:0] small_exp(input int idx);
    return model(idx, idx >= 0, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 3);
  endfunction

  initial begin
    int idx, nsec;
    logic [28:0] e;

    tbl[0]  = '{1'b0,   2, 11'd1039, 11'd665, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1,   1, 11'd0,    11'd0,   1, 0, 0, 1, 1, 1};
    tbl[2]  = '{1'b1, 799, 11'd799,  11'd0,   1, 0, 0, 1, 0, 0};
    tbl[3]  = '{1'b1,   1, 11'd800,  11'd0,   0, 0, 0, 1, 0, 0};
    tbl[4]  = '{1'b1,  55, 11'd855,  11'd0,   0, 0, 0, 1, 0, 0};
    tbl[5]  = '{1'b1,   1, 11'd856,  11'd0,   0, 1, 0, 1, 0, 0};
    tbl[6]  = '{1'b1, 119, 11'd975,  11'd0,   0, 1, 0, 1, 0, 0};
    tbl[7]  = '{1'b1,   1, 11'd976,  11'd0,   0, 0, 0, 1, 0, 0};
    tbl[8]  = '{1'b1,  64, 11'd0,    11'd1,   1, 0, 0, 1, 1, 0};
    tbl[9]  = '{1'b0,   1, 11'd1039, 11'd665, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1'b1,   1, 11'd0,    11'd0,   1, 0, 0, 1, 1, 1};

    @(negedge clk);

    // default timing, table-driven
    foreach (tbl[i]) begin
      rst_d = tbl[i].rst;
      repeat (tbl[i].adv) @(posedge clk);
      @(negedge clk);
      chk($sformatf("def_vec%0d", i),
          {d_x, d_y, d_von, d_hs, d_vs, d_pt, d_ls, d_fs, d_st},
          {tbl[i].x, tbl[i].y, tbl[i].von, tbl[i].hs, tbl[i].vs,
           tbl[i].pt, tbl[i].ls, tbl[i].fs, 1'b0});
    end

    // CLK_DIV=2, SYNC_POL=0 over two lines
    chk("div_reset",
        {c_x, c_y, c_von, c_hs, c_vs, c_pt, c_ls, c_fs, c_st},
        model(-1, 0, 800, 56, 120, 64, 600, 37, 6, 23, 1'b0, 72));
    rst_c = 1'b1;
    for (int k = 1; k <= 2084; k++) begin
      @(negedge clk);
      idx = (k >= 2) ? (k / 2 - 1) : -1;
      e = model(idx, (k % 2) == 0, 800, 56, 120, 64, 600, 37, 6, 23,
                1'b0, 72);
      chk($sformatf("div_k%0d", k),
          {c_x, c_y, c_von, c_hs, c_vs, c_pt, c_ls, c_fs, c_st}, e);
    end

    // small frame: vertical timing and sec_tick over 7 frames
    chk("small_reset",
        {s_x, s_y, s_von, s_hs, s_vs, s_pt, s_ls, s_fs, s_st},
        small_exp(-1));
    rst_s = 1'b1;
    nsec = 0;
    for (int k = 1; k <= 736; k++) begin
      @(negedge clk);
      if (s_st) nsec++;
      chk($sformatf("small_k%0d", k),
          {s_x, s_y, s_von, s_hs, s_vs, s_pt, s_ls, s_fs, s_st},
          small_exp(k - 1));
    end
    checks++;
    if (nsec != 2) begin
      errors++;
      $display("FAIL small_sec_count got %0d want 2", nsec);
    end

    // mid-frame reset: frame counter must restart as well
    rst_s = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("mid_rst%0d", k),
          {s_x, s_y, s_von, s_hs, s_vs, s_pt, s_ls, s_fs, s_st},
          small_exp(-1));
    end
    rst_s = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      chk($sformatf("post_k%0d", k),
          {s_x, s_y, s_von, s_hs, s_vs, s_pt, s_ls, s_fs, s_st},
          small_exp(k - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing-source end of the VGA pixel interface. Generates hsync/vsync, video_on and the x/y pixel coordinates consumed by the pixel generators, such as the countdown display.
- Default timing is 800x600@72Hz from a 50 MHz clock: 1040 total clocks per line, 666 total lines per frame.
- Also emits per-pixel, line-start, frame-start and one-second strobes. The countdown logic uses the one-second strobe to decrement its digit.

Parameters:
H_VIS 800 visible pixels per line
H_FP 56 horizontal front porch
H_SYNC 120 hsync width
H_BP 64 horizontal back porch
V_VIS 600 visible lines
V_FP 37 vertical front porch
V_SYNC 6 vsync width
V_BP 23 vertical back porch
SYNC_POL 1 active level of hsync/vsync (1 = positive)
CLK_DIV 1 clk cycles per pixel (>=1)
FRAMES_PER_SEC 72 frames per sec_tick

Ports:
clk in 1 system clock
rst_n in 1 synchronous active-low reset
x out 11 horizontal counter, 0..H_TOTAL-1
y out 11 vertical counter, 0..V_TOTAL-1
video_on out 1 high when x<H_VIS and y<V_VIS
hsync out 1 horizontal sync
vsync out 1 vertical sync
p_tick out 1 one-clk pulse: new pixel coordinates valid
line_start out 1 one-clk pulse when x becomes 0
frame_start out 1 one-clk pulse when (x,y) becomes (0,0)
sec_tick out 1 one-clk pulse every FRAMES_PER_SEC frames

Behaviour:
- Derived constants: H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP, V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP.
- Reset: synchronous, active-low. While rst_n=0 at a clk edge the registers load:
  - x=H_TOTAL-1, y=V_TOTAL-1
  - video_on=0, hsync=vsync=~SYNC_POL
  - p_tick=line_start=frame_start=sec_tick=0
  - divider=0, frame counter=0
  - The same applies when reset is asserted mid-frame; recovery takes effect on the next edge.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - en=(div_cnt==CLK_DIV-1).
  - With CLK_DIV=1, en=1 every cycle out of reset.
- Counter advance: counters change only on edges where en=1.
  - x increments; at H_TOTAL-1 it wraps to 0 and y increments.
  - y wraps from V_TOTAL-1 to 0.
  - The first en edge after reset therefore yields (0,0).
- Registered, glitch-free outputs: video_on, hsync and vsync are flops loaded with the decode of the next counter values on the same edge as x/y. They are always consistent with the x/y presented, with zero skew.
- Sync decode:
  - hsync=SYNC_POL when H_VIS+H_FP <= x < H_VIS+H_FP+H_SYNC (default 856..975).
  - vsync=SYNC_POL when V_VIS+V_FP <= y < V_VIS+V_FP+V_SYNC (default 637..642).
  - Otherwise ~SYNC_POL.
- Strobes:
  - p_tick=en registered, i.e. high for the one clk following each counter update.
  - line_start=1 in the p_tick cycle where x=0.
  - frame_start=1 in the p_tick cycle where x=0 and y=0.
  - All strobes are 0 outside p_tick cycles.
- Seconds:
  - A 7-bit frame counter increments on each frame_start event.
  - On reaching FRAMES_PER_SEC-1 it wraps to 0, and sec_tick pulses in the same cycle as that frame_start.
  - The first sec_tick occurs at the FRAMES_PER_SEC-th frame_start after reset.
- Widths: 11-bit counters; H_TOTAL and V_TOTAL must each be <=2048.
- No input other than clk/rst_n exists; no handshake back-pressure. Downstream must sample on p_tick when CLK_DIV>1.

Test Plan:
- Reset release, defaults:
  - While rst_n=0: x=1039, y=665, video_on=0, hsync=vsync=0.
  - First edge after release: x=0, y=0, video_on=1, p_tick=1, line_start=1, frame_start=1.
- Horizontal timing, one line, defaults:
  - video_on=1 for x=0..799 and 0 for 800..1039.
  - hsync=1 exactly for x=856..975 (120 clks).
  - Line period is 1040 clks.
- Vertical timing, defaults:
  - vsync=1 exactly for y=637..642 (6 lines = 6240 clks).
  - Frame period is 692640 clks; frame_start pulses once per frame.
- Mid-frame reset:
  - Assert rst_n=0 at x=400, y=300 for 3 clks.
  - Outputs return to reset values on the first reset edge.
  - Release gives (0,0) with frame_start=1 on the next edge.
  - frame counter restarts, so the next sec_tick is delayed to 72 frames after release.
- CLK_DIV=2, SYNC_POL=0:
  - x advances every 2 clks; p_tick toggles 1,0,1,0.
  - hsync=0 exactly during x=856..975, and 1 elsewhere.
  - Strobes are never high in non-p_tick cycles.
- Seconds, small config:
  - Config: H_VIS=8, H_FP=H_SYNC=H_BP=2, V_VIS=4, V_FP=V_SYNC=V_BP=1, FRAMES_PER_SEC=3.
  - Frame = 14x7 = 98 clks.
  - sec_tick pulses coincident with every 3rd frame_start: the first at 196 clks after the first frame_start, then every 294 clks.
